// File: rtl/bin_to_bcd_display_if.sv
// Handshake and result bundle for the binary-to-BCD display converter.
//   start  : request a conversion of value (driven by master)
//   value  : two's-complement operand (driven by master)
//   busy   : conversion in progress
//   done   : one-cycle pulse, result fields valid from this edge
//   bcd    : packed BCD digits, digit 0 in [3:0]
//   neg    : captured operand was negative
//   ovf    : magnitude does not fit in DIGITS decimal digits
//   blank  : per-digit leading-zero suppression mask
interface bin_to_bcd_display_if #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DIGITS = 6
) ();
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, value,
    input  busy, done, bcd, neg, ovf, blank
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, neg, ovf, blank
  );
endinterface

// File: rtl/bin_to_bcd_display.sv
// Sequential double-dabble converter: two's-complement operand in, packed BCD digits,
// sign, overflow and leading-zero blank mask out. One bit shifted per cycle.
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : slave side of bin_to_bcd_display_if (start/value in; busy/done/bcd/neg/ovf/blank out)
// All outputs come straight from registers.
module bin_to_bcd_display #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned DIGITS = 6
) (
  input logic                 clock,
  input logic                 reset,
  bin_to_bcd_display_if.slave bus
);

  localparam int unsigned BcdW = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]       MaxVal    = pow10(DIGITS) - 64'd1;
  // Display shows a single "0": every digit blanked except digit 0.
  localparam logic [DIGITS-1:0] BlankZero = ~DIGITS'(1);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e            state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic              sign_q, sign_d;
  logic              ovf_n_q, ovf_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic [DIGITS-1:0] blank_q, blank_d;

  logic [WIDTH-1:0]  mag_in;
  logic [BcdW-1:0]   adj;
  logic [DIGITS-1:0] fin_blank;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
  assign mag_in = bus.value[WIDTH-1] ? (~bus.value + WIDTH'(1)) : bus.value;

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                     : scratch_q[4*i +: 4];
    end
  end

  // Digit i is blanked when it and every higher digit is zero; digit 0 never blanks.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    fin_blank  = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_above   = zero_above & (scratch_q[4*i +: 4] == 4'd0);
      fin_blank[i] = zero_above;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    sign_d    = sign_q;
    ovf_n_d   = ovf_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    blank_d   = blank_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mag_d     = mag_in;
          sign_d    = bus.value[WIDTH-1];
          ovf_n_d   = 64'(mag_in) > MaxVal;
          scratch_d = '0;
          count_d   = '0;
          busy_d    = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        // One extra cycle after the last shift keeps done at WIDTH+2 edges.
        if (count_q == 6'(WIDTH)) begin
          state_d = StFinish;
        end else begin
          scratch_d = {adj[BcdW-2:0], mag_q[WIDTH-1]};
          mag_d     = {mag_q[WIDTH-2:0], 1'b0};
          count_d   = count_q + 6'd1;
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        neg_d   = sign_q;
        ovf_d   = ovf_n_q;
        if (ovf_n_q) begin
          bcd_d   = {DIGITS{4'hE}};
          blank_d = '0;
        end else begin
          bcd_d   = scratch_q;
          blank_d = fin_blank;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      mag_q     <= '0;
      scratch_q <= '0;
      sign_q    <= 1'b0;
      ovf_n_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      blank_q   <= BlankZero;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      sign_q    <= sign_d;
      ovf_n_q   <= ovf_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.neg   = neg_q;
  assign bus.ovf   = ovf_q;
  assign bus.blank = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed bench for bin_to_bcd_display (WIDTH=24, DIGITS=6).
module tb_bin_to_bcd_display;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bin_to_bcd_display_if #(.WIDTH(24), .DIGITS(6)) bus ();

  bin_to_bcd_display #(.WIDTH(24), .DIGITS(6)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [23:0] value;
    logic [23:0] bcd;
    logic        neg;
    logic        ovf;
    logic [5:0]  blank;
  } vec_t;

  vec_t vecs[14];

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] prev_bcd;
  logic [5:0]  prev_blank;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  lat;
    bit  got;
    string tag;
    tag = $sformatf("vec%0d(%06h)", idx, v.value);
    @(negedge clk);
    bus.value = v.value;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.value = 24'hA5A5A5;  // later changes must not affect the result
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) begin
        check({tag, " bcd_hold"}, 32'(bus.bcd), 32'(prev_bcd));
        check({tag, " blank_hold"}, 32'(bus.blank), 32'(prev_blank));
      end
      if (bus.done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'd26);
    check({tag, " bcd"}, 32'(bus.bcd), 32'(v.bcd));
    check({tag, " neg"}, 32'(bus.neg), 32'(v.neg));
    check({tag, " ovf"}, 32'(bus.ovf), 32'(v.ovf));
    check({tag, " blank"}, 32'(bus.blank), 32'(v.blank));
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    prev_bcd   = v.bcd;
    prev_blank = v.blank;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check({tag, " bcd"}, 32'(bus.bcd), 32'h000000);
    check({tag, " blank"}, 32'(bus.blank), 32'b111110);
    check({tag, " neg"}, 32'(bus.neg), 32'd0);
    check({tag, " ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    int n_done;
    int done_at[4];

    vecs[0]  = '{24'd123456,   24'h123456, 1'b0, 1'b0, 6'b000000};
    vecs[1]  = '{24'hFFFFD6,   24'h000042, 1'b1, 1'b0, 6'b111100};
    vecs[2]  = '{24'd999999,   24'h999999, 1'b0, 1'b0, 6'b000000};
    vecs[3]  = '{24'd1000000,  24'hEEEEEE, 1'b0, 1'b1, 6'b000000};
    vecs[4]  = '{24'h800000,   24'hEEEEEE, 1'b1, 1'b1, 6'b000000};
    vecs[5]  = '{24'd0,        24'h000000, 1'b0, 1'b0, 6'b111110};
    vecs[6]  = '{24'd7,        24'h000007, 1'b0, 1'b0, 6'b111110};
    vecs[7]  = '{24'hFFFFFF,   24'h000001, 1'b1, 1'b0, 6'b111110};
    vecs[8]  = '{24'd100000,   24'h100000, 1'b0, 1'b0, 6'b000000};
    vecs[9]  = '{24'd1050,     24'h001050, 1'b0, 1'b0, 6'b110000};
    vecs[10] = '{24'h7FFFFF,   24'hEEEEEE, 1'b0, 1'b1, 6'b000000};
    vecs[11] = '{-24'd999999,  24'h999999, 1'b1, 1'b0, 6'b000000};
    vecs[12] = '{-24'd1000000, 24'hEEEEEE, 1'b1, 1'b1, 6'b000000};
    vecs[13] = '{24'd90,       24'h000090, 1'b0, 1'b0, 6'b111100};

    // Reset state
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst        = 1'b0;
    prev_bcd   = 24'h000000;
    prev_blank = 6'b111110;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // start pulses while busy must not produce a second done
    @(negedge clk);
    bus.value = 24'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n_done = 0;
    done_at[0] = -1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (n_done == 0) done_at[0] = e;
        n_done++;
      end
      bus.start = (e == 5 || e == 15 || e == 25);
    end
    bus.start = 1'b0;
    check("busy_start done_count", 32'(n_done), 32'd1);
    check("busy_start done_edge", 32'(done_at[0]), 32'd26);
    check("busy_start bcd", 32'(bus.bcd), 32'h000005);

    // start held high: one done every WIDTH+3 cycles
    @(negedge clk);
    bus.value = 24'd0;
    bus.start = 1'b1;
    n_done = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (n_done < 4) done_at[n_done] = e;
        n_done++;
      end
    end
    bus.start = 1'b0;
    check("held_start done_count", 32'(n_done), 32'd3);
    if (n_done >= 3) begin
      check("held_start period1", 32'(done_at[1] - done_at[0]), 32'd27);
      check("held_start period2", 32'(done_at[2] - done_at[1]), 32'd27);
    end
    repeat (30) @(posedge clk);
    #1;
    check("held_start zero_blank", 32'(bus.blank), 32'b111110);

    // reset in the middle of a conversion aborts it
    @(negedge clk);
    bus.value = 24'd777;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals("mid_reset");
    n_done = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) n_done++;
    end
    check("mid_reset no_done", 32'(n_done), 32'd0);
    prev_bcd   = 24'h000000;
    prev_blank = 6'b111110;
    run_vec(99, '{24'd777, 24'h000777, 1'b0, 1'b0, 6'b111000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
